// File: rtl/uart_rx_cfg.sv
// Configurable UART receiver: 5-9 data bits, none/even/odd parity, 1-2 stop bits,
// fractional baud tick, 3-sample majority vote, valid/ready output with error status.
module uart_rx_cfg #(
    parameter int unsigned CLOCK_RATE    = 25000000,
    parameter int unsigned BAUD_RATE     = 115200,
    parameter int unsigned RX_OVERSAMPLE = 16,
    parameter int unsigned DATA_BITS     = 8,
    parameter int unsigned PARITY_MODE   = 0,
    parameter int unsigned STOP_BITS     = 1
) (
    input  logic                 clk,
    input  logic                 reset,
    input  logic                 i_rx_data,
    output logic [DATA_BITS-1:0] o_rx_byte,
    output logic                 o_rx_valid,
    input  logic                 i_rx_ready,
    output logic                 o_frame_err,
    output logic                 o_parity_err,
    output logic                 o_break,
    output logic                 o_overrun,
    output logic                 o_rx_busy
);
    localparam int unsigned ACC_W = $clog2(CLOCK_RATE) + 2;
    localparam int unsigned CNT_W = $clog2(RX_OVERSAMPLE);
    localparam int unsigned M     = RX_OVERSAMPLE / 2;
    localparam logic [ACC_W-1:0] INC   = ACC_W'(BAUD_RATE * RX_OVERSAMPLE);
    localparam logic [ACC_W-1:0] CLK_C = ACC_W'(CLOCK_RATE);
    localparam logic ODD = (PARITY_MODE == 2);

    localparam logic [2:0] S_IDLE     = 3'd0;
    localparam logic [2:0] S_START    = 3'd1;
    localparam logic [2:0] S_DATA     = 3'd2;
    localparam logic [2:0] S_PARITY   = 3'd3;
    localparam logic [2:0] S_STOP     = 3'd4;
    localparam logic [2:0] S_DELIVER  = 3'd5;
    localparam logic [2:0] S_BRK_WAIT = 3'd6;

    logic [1:0]           sync_q;
    logic                 prev_q;
    logic                 rx_s;
    logic [2:0]           state_q, state_d;
    logic [ACC_W-1:0]     acc_q, acc_d, sum_c;
    logic                 tick;
    logic [CNT_W-1:0]     cnt_q, cnt_d;
    logic [1:0]           smp_q, smp_d;
    logic                 dec_en, dec_bit;
    logic [3:0]           idx_q, idx_d;
    logic [DATA_BITS-1:0] shift_q, shift_d;
    logic                 par_q, par_d, perr_q, perr_d, ferr_q, ferr_d, ones_q, ones_d;
    logic [DATA_BITS-1:0] byte_q, byte_d;
    logic                 valid_q, valid_d, frame_err_q, frame_err_d;
    logic                 parity_err_q, parity_err_d, break_q, break_d, overrun_q, overrun_d;

    assign rx_s    = sync_q[1];
    assign sum_c   = acc_q + INC;
    assign tick    = (sum_c >= CLK_C);
    assign dec_en  = tick && (cnt_q == CNT_W'(M + 1));
    assign dec_bit = (smp_q[0] & smp_q[1]) | (smp_q[0] & rx_s) | (smp_q[1] & rx_s);

    always_comb begin
        state_d      = state_q;
        acc_d        = tick ? sum_c - CLK_C : sum_c;
        cnt_d        = cnt_q;
        smp_d        = smp_q;
        idx_d        = idx_q;
        shift_d      = shift_q;
        par_d        = par_q;
        perr_d       = perr_q;
        ferr_d       = ferr_q;
        ones_d       = ones_q;
        byte_d       = byte_q;
        valid_d      = valid_q;
        frame_err_d  = frame_err_q;
        parity_err_d = parity_err_q;
        break_d      = break_q;
        overrun_d    = 1'b0;

        if (tick) begin
            cnt_d = (cnt_q == CNT_W'(RX_OVERSAMPLE - 1)) ? '0 : cnt_q + 1'b1;
            if (cnt_q == CNT_W'(M - 1)) smp_d[0] = rx_s;
            if (cnt_q == CNT_W'(M))     smp_d[1] = rx_s;
        end

        // Status flags only mean something alongside valid, so they drop with it.
        if (valid_q && i_rx_ready) begin
            valid_d      = 1'b0;
            frame_err_d  = 1'b0;
            parity_err_d = 1'b0;
            break_d      = 1'b0;
        end

        case (state_q)
            S_IDLE: begin
                if (prev_q && !rx_s) begin
                    cnt_d   = '0;
                    state_d = S_START;
                end
            end
            S_START: begin
                if (dec_en) begin
                    state_d = dec_bit ? S_IDLE : S_DATA;
                    idx_d   = '0;
                    par_d   = 1'b0;
                    perr_d  = 1'b0;
                    ferr_d  = 1'b0;
                    ones_d  = 1'b0;
                end
            end
            S_DATA: begin
                if (dec_en) begin
                    shift_d = {dec_bit, shift_q[DATA_BITS-1:1]};
                    par_d   = par_q ^ dec_bit;
                    ones_d  = ones_q | dec_bit;
                    if (idx_q == 4'(DATA_BITS - 1)) begin
                        idx_d   = '0;
                        state_d = (PARITY_MODE != 0) ? S_PARITY : S_STOP;
                    end else begin
                        idx_d = idx_q + 4'd1;
                    end
                end
            end
            S_PARITY: begin
                if (dec_en) begin
                    ones_d  = ones_q | dec_bit;
                    perr_d  = par_q ^ dec_bit ^ ODD;
                    state_d = S_STOP;
                end
            end
            S_STOP: begin
                if (dec_en) begin
                    ones_d = ones_q | dec_bit;
                    if (!dec_bit) ferr_d = 1'b1;
                    if (idx_q == 4'(STOP_BITS - 1)) state_d = S_DELIVER;
                    else                             idx_d   = idx_q + 4'd1;
                end
            end
            S_DELIVER: begin
                if (!valid_q || i_rx_ready) begin
                    byte_d       = shift_q;
                    valid_d      = 1'b1;
                    frame_err_d  = ferr_q;
                    parity_err_d = perr_q;
                    break_d      = !ones_q;
                end else begin
                    overrun_d = 1'b1;
                end
                state_d = ones_q ? S_IDLE : S_BRK_WAIT;
            end
            S_BRK_WAIT: begin
                if (rx_s) state_d = S_IDLE;
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            sync_q       <= 2'b11;
            prev_q       <= 1'b1;
            state_q      <= S_IDLE;
            acc_q        <= '0;
            cnt_q        <= '0;
            smp_q        <= '0;
            idx_q        <= '0;
            shift_q      <= '0;
            par_q        <= 1'b0;
            perr_q       <= 1'b0;
            ferr_q       <= 1'b0;
            ones_q       <= 1'b0;
            byte_q       <= '0;
            valid_q      <= 1'b0;
            frame_err_q  <= 1'b0;
            parity_err_q <= 1'b0;
            break_q      <= 1'b0;
            overrun_q    <= 1'b0;
        end else begin
            sync_q       <= {sync_q[0], i_rx_data};
            prev_q       <= rx_s;
            state_q      <= state_d;
            acc_q        <= acc_d;
            cnt_q        <= cnt_d;
            smp_q        <= smp_d;
            idx_q        <= idx_d;
            shift_q      <= shift_d;
            par_q        <= par_d;
            perr_q       <= perr_d;
            ferr_q       <= ferr_d;
            ones_q       <= ones_d;
            byte_q       <= byte_d;
            valid_q      <= valid_d;
            frame_err_q  <= frame_err_d;
            parity_err_q <= parity_err_d;
            break_q      <= break_d;
            overrun_q    <= overrun_d;
        end
    end

    assign o_rx_byte    = byte_q;
    assign o_rx_valid   = valid_q;
    assign o_frame_err  = frame_err_q;
    assign o_parity_err = parity_err_q;
    assign o_break      = break_q;
    assign o_overrun    = overrun_q;
    assign o_rx_busy    = (state_q != S_IDLE);
endmodule

// File: tb/tb_uart_rx_cfg.sv
// Bench for uart_rx_cfg: three instances (8N1, 8E1, 9O2) driven with serial frames,
// received words compared against expectations derived from the transmitted bits.
`timescale 1ns/1ps
module tb_uart_rx_cfg;
    localparam int BIT_CLKS = 217;

    logic       clk;
    logic       reset;
    logic [2:0] rx, rdy, valid, ferr, perr, brk, ovr, busy;
    logic [7:0] b0, b1;
    logic [8:0] b2;

    int n_cmp, n_err;
    int ovr_cnt [3];
    logic [11:0] q0[$], q1[$], q2[$];

    uart_rx_cfg #(.DATA_BITS(8), .PARITY_MODE(0), .STOP_BITS(1)) u_8n1 (
        .clk(clk), .reset(reset), .i_rx_data(rx[0]), .o_rx_byte(b0), .o_rx_valid(valid[0]),
        .i_rx_ready(rdy[0]), .o_frame_err(ferr[0]), .o_parity_err(perr[0]), .o_break(brk[0]),
        .o_overrun(ovr[0]), .o_rx_busy(busy[0]));
    uart_rx_cfg #(.DATA_BITS(8), .PARITY_MODE(1), .STOP_BITS(1)) u_8e1 (
        .clk(clk), .reset(reset), .i_rx_data(rx[1]), .o_rx_byte(b1), .o_rx_valid(valid[1]),
        .i_rx_ready(rdy[1]), .o_frame_err(ferr[1]), .o_parity_err(perr[1]), .o_break(brk[1]),
        .o_overrun(ovr[1]), .o_rx_busy(busy[1]));
    uart_rx_cfg #(.DATA_BITS(9), .PARITY_MODE(2), .STOP_BITS(2)) u_9o2 (
        .clk(clk), .reset(reset), .i_rx_data(rx[2]), .o_rx_byte(b2), .o_rx_valid(valid[2]),
        .i_rx_ready(rdy[2]), .o_frame_err(ferr[2]), .o_parity_err(perr[2]), .o_break(brk[2]),
        .o_overrun(ovr[2]), .o_rx_busy(busy[2]));

    initial clk = 1'b0;
    always #20 clk = ~clk;

    // Record every accepted word as {frame_err, parity_err, break, byte}.
    always @(negedge clk) begin
        if (valid[0] && rdy[0]) q0.push_back({ferr[0], perr[0], brk[0], 1'b0, b0});
        if (valid[1] && rdy[1]) q1.push_back({ferr[1], perr[1], brk[1], 1'b0, b1});
        if (valid[2] && rdy[2]) q2.push_back({ferr[2], perr[2], brk[2], b2});
        for (int k = 0; k < 3; k++) if (ovr[k]) ovr_cnt[k]++;
    end

    task automatic wait_clks(input int n);
        repeat (n) @(posedge clk);
        #1;
    endtask

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_cmp++;
        assert (obs === exp) else begin
            n_err++;
            $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    // Builds the line waveform for instance k and returns what a correct receiver reports.
    task automatic send_frame(input int k, input logic [8:0] data, input bit flip,
                              input bit stop0, input int nmax, output logic [11:0] exp);
        int db, pm, sb, nb;
        bit bits [16];
        logic [8:0] dm;
        bit pb, fe, pe, bk;
        case (k)
            0:       begin db = 8; pm = 0; sb = 1; end
            1:       begin db = 8; pm = 1; sb = 1; end
            default: begin db = 9; pm = 2; sb = 2; end
        endcase
        dm = (db == 9) ? data : {1'b0, data[7:0]};
        bits[0] = 1'b0;
        for (int i = 0; i < db; i++) bits[1 + i] = dm[i];
        nb = 1 + db;
        pb = (^dm) ^ (pm == 2) ^ flip;
        if (pm != 0) begin bits[nb] = pb; nb++; end
        for (int i = 0; i < sb; i++) begin bits[nb] = !stop0; nb++; end
        for (int i = 0; i < nb && i < nmax; i++) begin
            rx[k] = bits[i];
            wait_clks(BIT_CLKS);
        end
        rx[k] = 1'b1;
        fe = stop0;
        pe = (pm != 0) && ((((^dm) ^ pb) != 1'b0) != (pm == 2));
        bk = 1'b1;
        for (int i = 1; i < nb; i++) if (bits[i]) bk = 1'b0;
        exp = {fe, pe, bk, dm};
    endtask

    task automatic expect_frame(input int k, input string tag, input logic [11:0] exp);
        int sz;
        logic [11:0] got;
        sz = (k == 0) ? q0.size() : (k == 1) ? q1.size() : q2.size();
        check({tag, "_count"}, 32'(sz), 32'd1);
        if (sz > 0) begin
            case (k)
                0:       got = q0.pop_front();
                1:       got = q1.pop_front();
                default: got = q2.pop_front();
            endcase
            check({tag, "_byte"}, 32'(got[8:0]), 32'(exp[8:0]));
            check({tag, "_flags"}, 32'(got[11:9]), 32'(exp[11:9]));
        end
        q0.delete(); q1.delete(); q2.delete();
        check({tag, "_busy"}, 32'(busy[k]), 32'd0);
    endtask

    initial begin
        logic [11:0] e;
        logic [7:0]  dir [4];
        int          ov0;
        n_cmp = 0; n_err = 0;
        for (int k = 0; k < 3; k++) ovr_cnt[k] = 0;
        rx = '1; rdy = '1; reset = 1'b1;
        wait_clks(5);
        check("reset_status", 32'({valid, ferr, perr, brk, ovr, busy}), 32'd0);
        check("reset_bytes", 32'({b2, b1, b0}), 32'd0);
        reset = 1'b0;
        wait_clks(20);

        dir = '{8'h55, 8'hA5, 8'h00, 8'hFF};
        for (int i = 0; i < 4; i++) begin
            send_frame(0, {1'b0, dir[i]}, 1'b0, 1'b0, 99, e);
            wait_clks(40);
            expect_frame(0, "8n1_dir", e);
        end
        for (int i = 0; i < 2; i++) begin
            send_frame(0, 9'($urandom_range(255)), 1'b0, 1'b0, 99, e);
            wait_clks(40);
            expect_frame(0, "8n1_rand", e);
        end

        send_frame(1, 9'h0A5, 1'b0, 1'b0, 99, e);
        wait_clks(40);
        expect_frame(1, "8e1_good", e);
        send_frame(1, 9'h0A5, 1'b1, 1'b0, 99, e);
        wait_clks(40);
        expect_frame(1, "8e1_badpar", e);
        for (int i = 0; i < 2; i++) begin
            send_frame(1, 9'($urandom_range(255)), 1'($urandom_range(1)), 1'b0, 99, e);
            wait_clks(40);
            expect_frame(1, "8e1_rand", e);
        end

        send_frame(0, 9'h03C, 1'b0, 1'b1, 99, e);
        wait_clks(40);
        expect_frame(0, "8n1_stop0", e);

        send_frame(2, 9'h1A5, 1'b0, 1'b0, 99, e);
        wait_clks(40);
        expect_frame(2, "9o2_good", e);
        for (int i = 0; i < 2; i++) begin
            send_frame(2, 9'($urandom_range(511)), 1'($urandom_range(1)), 1'b0, 99, e);
            wait_clks(40);
            expect_frame(2, "9o2_rand", e);
        end

        // 2000 ns low glitch on an idle line
        rx[0] = 1'b0;
        wait_clks(50);
        check("glitch_busy_hi", 32'(busy[0]), 32'd1);
        rx[0] = 1'b1;
        wait_clks(BIT_CLKS - 50);
        check("glitch_busy_lo", 32'(busy[0]), 32'd0);
        check("glitch_novalid", 32'(q0.size()), 32'd0);

        // Break: line low for 20 bit periods
        rx[0] = 1'b0;
        wait_clks(20 * BIT_CLKS);
        check("brk_wait_busy", 32'(busy[0]), 32'd1);
        rx[0] = 1'b1;
        wait_clks(2 * BIT_CLKS);
        expect_frame(0, "break", 12'b101_000000000);
        send_frame(0, 9'h042, 1'b0, 1'b0, 99, e);
        wait_clks(40);
        expect_frame(0, "after_brk", e);
        check("no_ovr_yet", 32'(ovr_cnt[0] + ovr_cnt[1] + ovr_cnt[2]), 32'd0);

        // Overrun: consumer stalled for two frames
        rdy[0] = 1'b0;
        ov0 = ovr_cnt[0];
        send_frame(0, 9'h011, 1'b0, 1'b0, 99, e);
        wait_clks(40);
        send_frame(0, 9'h022, 1'b0, 1'b0, 99, e);
        wait_clks(40);
        check("ovr_pulses", 32'(ovr_cnt[0] - ov0), 32'd1);
        check("ovr_valid", 32'(valid[0]), 32'd1);
        check("ovr_held", 32'(b0), 32'h11);
        rdy[0] = 1'b1;
        wait_clks(3);
        expect_frame(0, "ovr_accept", e & 12'h000 | 12'h011);
        check("ovr_valid_drop", 32'(valid[0]), 32'd0);

        // Reset in the middle of 0x33
        send_frame(0, 9'h033, 1'b0, 1'b0, 5, e);
        reset = 1'b1;
        wait_clks(3);
        check("midrst_status", 32'({valid[0], ferr[0], perr[0], brk[0], ovr[0], busy[0]}), 32'd0);
        check("midrst_byte", 32'(b0), 32'd0);
        reset = 1'b0;
        wait_clks(BIT_CLKS);
        check("midrst_novalid", 32'(q0.size()), 32'd0);
        send_frame(0, 9'h044, 1'b0, 1'b0, 99, e);
        wait_clks(40);
        expect_frame(0, "after_rst", e);

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
        $finish;
    end
endmodule
